// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
`timescale 1ns/1ps
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  localparam logic [31:0] ILLEGAL_ZERO = 32'h0000_0000;
  localparam logic [31:0] ILLEGAL_ONES = 32'hFFFF_FFFF;
  localparam int DEFAULT_RESET_PC = 0;

  function automatic logic is_illegal(input logic [31:0] word);
    return (word == ILLEGAL_ZERO) || (word == ILLEGAL_ONES);
  endfunction

endpackage

// File: rtl/cpu_seq_pc.sv
// Program counter: advances once per executed instruction, either to a redirect target or pc+1.
`timescale 1ns/1ps
module cpu_seq_pc #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clck,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Increment wraps naturally at the address width.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RST;
    end else if (advance) begin
      pc <= redirect_valid ? redirect_pc : (pc + PC_ONE);
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer for the lab RISC-V core.
// Optional single-step from HALT is enabled by defining CPU_SEQ_STEP_EN.
//
// state | meaning
// IDLE  | quiet, waiting for run
// FETCH | issue instruction RAM read at pc
// WAIT  | MEM_LAT cycles of read latency; latch word on the last one
// EXEC  | one-cycle architectural write strobe, advance pc
// HALT  | stopped; run=0 returns to IDLE
`timescale 1ns/1ps
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = DEFAULT_RESET_PC,
  parameter int MEM_LAT  = 1
) (
  input  logic              clck,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt_req,
`ifdef CPU_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              exec_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);

  localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);
  localparam logic [1:0]        WAIT_INIT = 2'(MEM_LAT - 1);

  seq_state_t        state;
  seq_state_t        next_state;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic              step_mode;
  logic              step_go;
  logic              wait_last;
  logic              word_bad;

`ifdef CPU_SEQ_STEP_EN
  assign step_go = step && !illegal;
`else
  assign step_go = 1'b0;
`endif

  assign wait_last = (state == WAIT) && (wait_cnt == 2'd0);
  assign word_bad  = is_illegal(imem_rdata);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (run) next_state = FETCH;
      FETCH: next_state = WAIT;
      WAIT:  if (wait_cnt == 2'd0) next_state = word_bad ? HALT : EXEC;
      EXEC:  next_state = (step_mode || halt_req || !run) ? HALT : FETCH;
      HALT: begin
        if (step_go)   next_state = FETCH;
        else if (!run) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      instr     <= 32'h0;
      illegal   <= 1'b0;
      retired   <= 32'h0;
      addr_hold <= PC_RST;
      step_mode <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH) begin
        wait_cnt  <= WAIT_INIT;
        addr_hold <= pc;
      end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (wait_last) begin
        instr <= imem_rdata;
        if (word_bad) illegal <= 1'b1;
      end
      if (state == EXEC) retired <= retired + 32'd1;
      // A step-launched instruction always returns to HALT, regardless of run/halt_req.
      if ((state == HALT) && step_go) step_mode <= 1'b1;
      else if (state == EXEC)         step_mode <= 1'b0;
    end
  end

  assign imem_en   = (state == FETCH);
  assign imem_addr = (state == FETCH) ? pc : addr_hold;
  assign exec_en   = (state == EXEC);
  assign halted    = (state == HALT);

  cpu_seq_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clck           (clck),
    .rst_n          (rst_n),
    .advance        (state == EXEC),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: one instance with MEM_LAT=1, one with MEM_LAT=3.
`timescale 1ns/1ps
module tb_cpu_seq_ctrl;

  localparam logic [31:0] ADDI = 32'h0010_8093;

  logic clck = 1'b0;
  always #5 clck = ~clck;

  // MEM_LAT=1 instance
  logic        rst_n, run, halt_req, redirect_valid;
  logic [11:0] redirect_pc;
  logic        imem_en, exec_en, halted, illegal;
  logic [11:0] imem_addr, pc;
  logic [31:0] imem_rdata, instr, retired;
  logic [31:0] mem [0:4095];

  // MEM_LAT=3 instance
  logic        rst_n_3, run_3, halt_req_3;
  logic        imem_en_3, exec_en_3, halted_3, illegal_3;
  logic [11:0] imem_addr_3, pc_3;
  logic [31:0] instr_3, retired_3;
  logic [31:0] pipe_3 [0:2];
`ifdef CPU_SEQ_STEP_EN
  logic step, step_3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cpu_seq_ctrl #(.ADDR_W(12), .RESET_PC(0), .MEM_LAT(1)) dut (
    .clck(clck), .rst_n(rst_n), .run(run), .halt_req(halt_req),
`ifdef CPU_SEQ_STEP_EN
    .step(step),
`endif
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .exec_en(exec_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc(pc), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  cpu_seq_ctrl #(.ADDR_W(12), .RESET_PC(0), .MEM_LAT(3)) dut3 (
    .clck(clck), .rst_n(rst_n_3), .run(run_3), .halt_req(halt_req_3),
`ifdef CPU_SEQ_STEP_EN
    .step(step_3),
`endif
    .imem_en(imem_en_3), .imem_addr(imem_addr_3), .imem_rdata(pipe_3[2]),
    .instr(instr_3), .exec_en(exec_en_3), .redirect_valid(1'b0),
    .redirect_pc(12'h000), .pc(pc_3), .halted(halted_3), .illegal(illegal_3),
    .retired(retired_3)
  );

  // Synchronous RAM models: data valid 1 (resp. 3) cycles after the enable cycle.
  initial imem_rdata = 32'h0;
  always @(posedge clck) if (imem_en) imem_rdata <= mem[imem_addr];

  initial for (int i = 0; i < 3; i++) pipe_3[i] = 32'h0;
  always @(posedge clck) begin
    if (imem_en_3) pipe_3[0] <= ADDI;
    pipe_3[1] <= pipe_3[0];
    pipe_3[2] <= pipe_3[1];
  end

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 12'h000;
    repeat (2) tick();
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL rst_imem_en got %b want 0", imem_en); end
    n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL rst_exec_en got %b want 0", exec_en); end
    n_checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b want 00", halted, illegal); end
    n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL rst_pc got %h want 000", pc); end
    n_checks++; if (retired !== 32'h0 || instr !== 32'h0) begin n_fail++; $display("FAIL rst_regs got %h %h want 0 0", retired, instr); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL idle_quiet got %b want 0", imem_en); end
  endtask

  task automatic test_sequence();
    logic        want_en, want_ex;
    logic [11:0] want_addr;
    run = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      want_en   = (c % 3) == 1;
      want_ex   = (c % 3) == 0;
      want_addr = 12'((c - 1) / 3);
      n_checks++; if (imem_en !== want_en) begin n_fail++; $display("FAIL seq_imem_en c%0d got %b want %b", c, imem_en, want_en); end
      n_checks++; if (exec_en !== want_ex) begin n_fail++; $display("FAIL seq_exec_en c%0d got %b want %b", c, exec_en, want_ex); end
      if (want_en) begin
        n_checks++; if (imem_addr !== want_addr) begin n_fail++; $display("FAIL seq_addr c%0d got %h want %h", c, imem_addr, want_addr); end
      end
      if (c == 8) halt_req = 1'b1;
    end
    n_checks++; if (instr !== ADDI) begin n_fail++; $display("FAIL seq_instr got %h want %h", instr, ADDI); end
    tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_after_exec got %b want 1", halted); end
    n_checks++; if (retired !== 32'd3 || pc !== 12'd3) begin n_fail++; $display("FAIL seq_counts got %0d pc %h want 3 pc 003", retired, pc); end
    repeat (2) begin
      tick();
      n_checks++; if (imem_en !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_quiet got en %b halted %b want 0 1", imem_en, halted); end
    end
  endtask

  task automatic test_resume();
    halt_req = 1'b0; run = 1'b0;
    tick();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_to_idle got %b want 0", halted); end
    run = 1'b1;
    tick();
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 12'd3) begin n_fail++; $display("FAIL resume_fetch got en %b addr %h want 1 003", imem_en, imem_addr); end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (exec_en === 1'b1 && pc === 12'd5) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL redir_reach_pc5 got none want exec at pc 005"); end
    redirect_valid = 1'b1; redirect_pc = 12'h100;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 12'h100) begin n_fail++; $display("FAIL redir_pc got %h want 100", pc); end
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 12'h100) begin n_fail++; $display("FAIL redir_fetch got en %b addr %h want 1 100", imem_en, imem_addr); end
    n_checks++; if (exec_en !== 1'b0 || retired !== 32'd6) begin n_fail++; $display("FAIL redir_single got exec %b ret %0d want 0 6", exec_en, retired); end
    tick();
    n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL redir_wait_exec got %b want 0", exec_en); end
    tick();
    n_checks++; if (exec_en !== 1'b1 || pc !== 12'h100) begin n_fail++; $display("FAIL redir_exec got exec %b pc %h want 1 100", exec_en, pc); end
    // redirect and halt in the same EXEC
    redirect_valid = 1'b1; redirect_pc = 12'hFFF; halt_req = 1'b1;
    tick();
    redirect_valid = 1'b0; halt_req = 1'b0;
    n_checks++; if (halted !== 1'b1 || pc !== 12'hFFF || retired !== 32'd7) begin n_fail++; $display("FAIL redir_halt got halted %b pc %h ret %0d want 1 fff 7", halted, pc, retired); end
  endtask

  task automatic test_wrap();
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 12'hFFF) begin n_fail++; $display("FAIL wrap_fetch got en %b addr %h want 1 fff", imem_en, imem_addr); end
    tick();
    tick();
    n_checks++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL wrap_exec got %b want 1", exec_en); end
    tick();
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 12'h000 || pc !== 12'h000) begin n_fail++; $display("FAIL wrap_zero got en %b addr %h pc %h want 1 000 000", imem_en, imem_addr, pc); end
    n_checks++; if (retired !== 32'd8) begin n_fail++; $display("FAIL wrap_retired got %0d want 8", retired); end
  endtask

  task automatic test_illegal();
    int   execs = 0;
    logic seen  = 1'b0;
    mem[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (exec_en === 1'b1) execs++;
      if (halted === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || execs != 3) begin n_fail++; $display("FAIL ill_trap got halted %b execs %0d want 1 3", seen, execs); end
    n_checks++; if (illegal !== 1'b1 || pc !== 12'd3 || retired !== 32'd11) begin n_fail++; $display("FAIL ill_state got ill %b pc %h ret %0d want 1 003 11", illegal, pc, retired); end
    n_checks++; if (instr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ill_instr got %h want ffffffff", instr); end
    run = 1'b0;
    tick();
    n_checks++; if (halted !== 1'b0 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill_idle got halted %b ill %b want 0 1", halted, illegal); end
    run = 1'b1; seen = 1'b0; execs = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (exec_en === 1'b1) execs++;
      if (halted === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || execs != 0 || illegal !== 1'b1 || retired !== 32'd11) begin n_fail++; $display("FAIL ill_retrap got halted %b execs %0d ill %b ret %0d want 1 0 1 11", seen, execs, illegal, retired); end
`ifdef CPU_SEQ_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    n_checks++; if (halted !== 1'b1 || imem_en !== 1'b0) begin n_fail++; $display("FAIL ill_step_ignored got halted %b en %b want 1 0", halted, imem_en); end
`endif
  endtask

  task automatic test_reset_midwait();
    rst_n_3 = 1'b0; run_3 = 1'b0; halt_req_3 = 1'b0;
    repeat (2) tick();
    rst_n_3 = 1'b1;
    run_3 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++; if (imem_en_3 !== (c == 1) || exec_en_3 !== (c == 5)) begin n_fail++; $display("FAIL lat3_timing c%0d got en %b exec %b want %b %b", c, imem_en_3, exec_en_3, c == 1, c == 5); end
    end
    tick();
    n_checks++; if (imem_addr_3 !== 12'd1 || retired_3 !== 32'd1 || instr_3 !== ADDI) begin n_fail++; $display("FAIL lat3_second got addr %h ret %0d instr %h want 001 1 %h", imem_addr_3, retired_3, instr_3, ADDI); end
    tick();
    tick();
    #2;
    rst_n_3 = 1'b0;
    #1;
    n_checks++; if (exec_en_3 !== 1'b0 || imem_en_3 !== 1'b0 || halted_3 !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl got exec %b en %b halted %b want 0 0 0", exec_en_3, imem_en_3, halted_3); end
    n_checks++; if (pc_3 !== 12'd0 || retired_3 !== 32'd0 || instr_3 !== 32'd0) begin n_fail++; $display("FAIL arst_regs got pc %h ret %0d instr %h want 000 0 0", pc_3, retired_3, instr_3); end
    tick();
    n_checks++; if (exec_en_3 !== 1'b0) begin n_fail++; $display("FAIL arst_no_exec got %b want 0", exec_en_3); end
    rst_n_3 = 1'b1;
    tick();
    n_checks++; if (imem_en_3 !== 1'b1 || imem_addr_3 !== 12'd0) begin n_fail++; $display("FAIL arst_restart got en %b addr %h want 1 000", imem_en_3, imem_addr_3); end
  endtask

`ifdef CPU_SEQ_STEP_EN
  task automatic test_step();
    int   execs = 0;
    logic seen  = 1'b0;
    halt_req_3 = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (halted_3 === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || retired_3 !== 32'd1) begin n_fail++; $display("FAIL step_pre_halt got halted %b ret %0d want 1 1", seen, retired_3); end
    halt_req_3 = 1'b0;
    step_3 = 1'b1;
    tick();
    step_3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (exec_en_3 === 1'b1) execs++;
      tick();
    end
    n_checks++; if (execs != 1 || halted_3 !== 1'b1) begin n_fail++; $display("FAIL step_one got execs %0d halted %b want 1 1", execs, halted_3); end
    n_checks++; if (pc_3 !== 12'd2 || retired_3 !== 32'd2) begin n_fail++; $display("FAIL step_counts got pc %h ret %0d want 002 2", pc_3, retired_3); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = ADDI;
    rst_n_3 = 1'b0; run_3 = 1'b0; halt_req_3 = 1'b0;
`ifdef CPU_SEQ_STEP_EN
    step = 1'b0; step_3 = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_resume();
    test_redirect();
    test_wrap();
    test_illegal();
    test_reset_midwait();
`ifdef CPU_SEQ_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
